// File: rtl/seg7_signed_decoder.sv
// Recovers a signed 4-bit value from a sign digit and a magnitude digit on two active-low
// seven-segment buses. Glitches are filtered out, and each stable pattern is reported once.
module seg7_signed_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_lo,
  input  logic [6:0] seg_hi,
  output logic [3:0] value,
  output logic       err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [13:0]      seg_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reported_q, reported_d;
  logic [3:0]       value_q;
  logic             err_q, valid_q, overrun_q;

  logic             same, emit;
  logic             dig_ok;
  logic [3:0]       dig;
  logic [3:0]       dec_val;
  logic             dec_err;

  assign same = ({seg_hi, seg_lo} == seg_q);
  assign emit = same && (cnt_q == CNT_MAX) && !reported_q && (seg_q != 14'h3FFF);

  always_comb begin
    cnt_d      = '0;
    reported_d = 1'b0;
    if (same) begin
      cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      reported_d = reported_q | emit;
    end
  end

  // Decode from the registered copy; it equals the input whenever emit is true.
  always_comb begin
    dig_ok = 1'b1;
    dig    = 4'd0;
    case (seg_q[6:0])
      7'b0000001: dig = 4'd0;
      7'b1001111: dig = 4'd1;
      7'b0010010: dig = 4'd2;
      7'b0000110: dig = 4'd3;
      7'b1001100: dig = 4'd4;
      7'b0100100: dig = 4'd5;
      7'b0100000: dig = 4'd6;
      7'b0001111: dig = 4'd7;
      7'b0000000: dig = 4'd8;
      default:    dig_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec_val = 4'd0;
    dec_err = 1'b1;
    if (dig_ok && seg_q[13:7] == 7'b1111111 && dig != 4'd8) begin
      dec_val = dig;
      dec_err = 1'b0;
    end else if (dig_ok && seg_q[13:7] == 7'b1111110 && dig != 4'd0) begin
      dec_val = ~dig + 4'd1;
      dec_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q      <= '0;
      cnt_q      <= '0;
      reported_q <= 1'b0;
      value_q    <= 4'd0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      seg_q      <= {seg_hi, seg_lo};
      cnt_q      <= cnt_d;
      reported_q <= reported_d;
      if (emit) begin
        if (!valid_q || out_ready) begin
          value_q <= dec_val;
          err_q   <= dec_err;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign value     = value_q;
  assign err       = err_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_signed_decoder.sv
// Directed bench for seg7_signed_decoder: a run-length reference model checked on every cycle,
// plus hand-computed expectations at key points.
module tb_seg7_signed_decoder;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_lo, seg_hi;
  logic [3:0] value;
  logic       err, out_valid, out_ready, overrun;

  seg7_signed_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .seg_lo(seg_lo), .seg_hi(seg_hi),
    .value(value), .err(err), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a result is due when the same input has been seen STABLE+1 times in a row.
  logic [6:0] dig_pat [9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000};
  logic [13:0] m_last;
  int          m_run;
  logic        m_valid, m_err, m_ovr, started = 1'b0;
  logic [3:0]  m_val;

  task automatic model_decode(input logic [6:0] hi, input logic [6:0] lo,
                              output logic [3:0] v, output logic e);
    int d = -1;
    int r;
    for (int i = 0; i < 9; i++) if (dig_pat[i] == lo) d = i;
    e = 1'b1;
    r = 0;
    if (hi == 7'h7F && d >= 0 && d <= 7) begin r = d; e = 1'b0; end
    if (hi == 7'h7E && d >= 1) begin r = -d; e = 1'b0; end
    v = 4'(r);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_last = 14'h0; m_run = 1;
      m_valid = 1'b0; m_val = 4'd0; m_err = 1'b0; m_ovr = 1'b0;
      started = 1'b1;
    end else if (started) begin
      if ({seg_hi, seg_lo} == m_last) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_last = {seg_hi, seg_lo};
        m_run = 1;
      end
      if (m_run == STABLE + 1 && m_last != 14'h3FFF) begin
        if (!m_valid || out_ready) begin
          model_decode(seg_hi, seg_lo, m_val, m_err);
          m_valid = 1'b1;
        end else m_ovr = 1'b1;
      end else if (m_valid && out_ready) m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_valid", out_valid, m_valid);
      chk("cyc_overrun", overrun, m_ovr);
      if (m_valid) begin
        chk("cyc_value", value, m_val);
        chk("cyc_err", err, m_err);
      end
    end
  end

  // Accepted-result monitor (samples pre-edge values).
  int         acc = 0;
  logic [3:0] last_val;
  logic       last_err;
  always @(posedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      acc++;
      last_val = value;
      last_err = err;
    end
  end

  task automatic drive(input logic [6:0] hi, input logic [6:0] lo, input logic rdy, input int n);
    seg_hi = hi; seg_lo = lo; out_ready = rdy;
    repeat (n) @(negedge clk);
  endtask

  int a0;

  initial begin
    rst_n = 1'b0;
    drive(7'h00, 7'h00, 1'b1, 2);
    chk("rst_value", value, 4'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);

    rst_n = 1'b1;
    a0 = acc;
    drive(7'h7F, 7'b0001111, 1'b1, 4);
    chk("lat_not_yet", out_valid, 1'b0);
    drive(7'h7F, 7'b0001111, 1'b1, 1);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_value", value, 4'b0111);
    chk("lat_err", err, 1'b0);
    drive(7'h7F, 7'b0001111, 1'b1, 20);
    chk("hold_once", acc - a0, 1);

    drive(7'h7E, 7'b0000000, 1'b1, 5);
    chk("neg8_valid", out_valid, 1'b1);
    chk("neg8_value", value, 4'b1000);
    chk("neg8_err", err, 1'b0);
    drive(7'h7E, 7'b0000000, 1'b1, 1);
    drive(7'h7E, 7'b1001111, 1'b1, 5);
    chk("neg1_value", value, 4'b1111);
    chk("neg1_err", err, 1'b0);
    drive(7'h7E, 7'b1001111, 1'b1, 1);
    drive(7'h7E, 7'b0100000, 1'b1, 5);
    chk("neg6_value", value, 4'b1010);
    chk("neg6_err", err, 1'b0);
    drive(7'h7E, 7'b0100000, 1'b1, 1);

    a0 = acc;
    drive(7'h7F, 7'b0000110, 1'b1, 2);
    drive(7'h7F, 7'b0100100, 1'b1, 3);
    chk("glitch_no_emit", acc - a0, 0);
    drive(7'h7F, 7'b0100100, 1'b1, 4);
    chk("glitch_one_emit", acc - a0, 1);
    chk("glitch_value", last_val, 4'b0101);

    a0 = acc;
    drive(7'h7F, 7'b1001111, 1'b1, 6);
    drive(7'h7F, 7'b0010010, 1'b1, 1);
    drive(7'h7F, 7'b1001111, 1'b1, 6);
    chk("rereport_count", acc - a0, 2);
    chk("rereport_value", last_val, 4'b0001);

    drive(7'h7E, 7'b0000001, 1'b1, 6);
    chk("neg0_err", last_err, 1'b1);
    chk("neg0_value", last_val, 4'd0);
    drive(7'h00, 7'b1001111, 1'b1, 6);
    chk("badsign_err", last_err, 1'b1);
    chk("badsign_value", last_val, 4'd0);
    drive(7'h7F, 7'b1111000, 1'b1, 6);
    chk("baddigit_err", last_err, 1'b1);
    drive(7'h7F, 7'b0000000, 1'b1, 6);
    chk("pos8_err", last_err, 1'b1);
    a0 = acc;
    drive(7'h7F, 7'h7F, 1'b1, 10);
    chk("blank_no_emit", acc - a0, 0);
    chk("blank_valid", out_valid, 1'b0);

    drive(7'h7F, 7'b0010010, 1'b0, 6);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_value", value, 4'b0010);
    chk("bp_no_ovr", overrun, 1'b0);
    drive(7'h7F, 7'b1001100, 1'b0, 6);
    chk("bp_held", value, 4'b0010);
    chk("bp_ovr", overrun, 1'b1);
    drive(7'h7F, 7'b0100000, 1'b0, 4);
    drive(7'h7F, 7'b0100000, 1'b1, 1);
    chk("swap_valid", out_valid, 1'b1);
    chk("swap_value", value, 4'b0110);
    chk("swap_ovr", overrun, 1'b1);
    drive(7'h7F, 7'b0100000, 1'b1, 3);
    chk("drain_valid", out_valid, 1'b0);
    chk("ovr_sticky", overrun, 1'b1);

    drive(7'h7F, 7'b0000110, 1'b1, 2);
    rst_n = 1'b0;
    drive(7'h7F, 7'b0000110, 1'b1, 1);
    chk("midrst_ovr", overrun, 1'b0);
    chk("midrst_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    drive(7'h7F, 7'b0000110, 1'b1, 8);
    chk("midrst_value", last_val, 4'b0011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_signed_decoder.md
Name: seg7_signed_decoder

Overview:
- Reverse path of the signed 4-bit seven-segment display encoder: reads the two active-low 7-segment buses (sign digit, magnitude digit) and recovers the 4-bit two's-complement value.
- Rejects glitches: a pattern must be stable for STABLE_CYCLES clocks before it is decoded.
- Each stable pattern is reported once through a valid/ready handshake; illegal patterns are flagged.
- Sits between a display-scanning or loopback source and test/checker logic.

Parameters:
STABLE_CYCLES, 4, consecutive clock edges a pattern must be held before it is decoded; legal range 1..255
CNT_W, 8, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  synchronous active-low reset
seg_lo  in  7  magnitude digit {a,b,c,d,e,f,g}, active-low (0 = segment lit)
seg_hi  in  7  sign digit {a1,b1,c1,d1,e1,f1,g1}, active-low
value  out  4  decoded two's-complement value (-8..7)
err  out  1  qualifies value: 1 = illegal pattern, value forced to 0
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
overrun  out  1  sticky: a result was dropped

Behaviour:
- Reset: one clk edge with rst_n=0 clears seg_q, stability count and reported flag. It also clears value=0, err=0, out_valid=0 and overrun=0.
- Sampling: {seg_hi,seg_lo} is registered into seg_q on every edge.
- Stability counter:
  - cnt <= cnt+1 (saturating at STABLE_CYCLES-1) when the input equals seg_q.
  - Otherwise cnt <= 0 and the reported flag clears, which starts a new episode.
- Emit condition: emit occurs on an edge when all of the following hold: input == seg_q, cnt == STABLE_CYCLES-1, reported == 0, and the pattern is not fully blank.
  - On emit, reported <= 1.
  - Latency: a pattern first sampled at edge k gives out_valid=1 after edge k+STABLE_CYCLES.
- Blank pattern (seg_hi = seg_lo = 7'b1111111): never emits and never flags an error.
- Sign digit decode:
  - 7'b1111111 = positive.
  - 7'b1111110 = negative (only segment g lit).
  - Any other sign pattern is illegal.
- Digit decode for seg_lo (active-low):
  - 0: 0000001
  - 1: 1001111
  - 2: 0010010
  - 3: 0000110
  - 4: 1001100
  - 5: 0100100
  - 6: 0100000
  - 7: 0001111
  - 8: 0000000
  - Any other pattern is illegal.
- Legal combinations and resulting value:
  - Positive with digits 0..7 -> value = digit.
  - Negative with digits 1..8 -> value = -digit (mod 16), e.g. -8 -> 4'b1000, -1 -> 4'b1111.
  - Positive 8 and negative 0 are illegal.
- Illegal combination: emits with err=1 and value=4'b0000.
- Handshake:
  - out_valid stays high and value/err stay stable until a clock edge with out_valid && out_ready. That edge clears out_valid unless an emit happens in the same edge.
  - Emit while out_valid=0, or with out_valid && out_ready on the same edge: load the new result and set out_valid=1 (no bubble, no overrun).
  - Emit while out_valid && !out_ready: discard the new result, keep the held one, set overrun=1. overrun clears only on reset.
- Re-reporting: the same pattern held indefinitely emits exactly once. After any change, including a one-cycle glitch back to the same pattern, it must re-qualify for the full STABLE_CYCLES and emit again.
- Reset mid-operation: all state clears. A pattern held through reset needs STABLE_CYCLES edges after rst_n returns high before it emits.
- STABLE_CYCLES=1: emits on the second consecutive matching edge, i.e. the edge after first sample.

Test Plan:
- Reset with rst_n=0 for 2 edges, inputs at 7'h00 -> value=0, err=0, out_valid=0, overrun=0.
- STABLE_CYCLES=4, out_ready=1, apply hi=1111111 lo=0001111 from edge 1 -> out_valid=1 only after edge 5, value=4'b0111, err=0. Exactly one pulse while the pattern is held 20 more cycles.
- Negative sweep, out_ready=1:
  - hi=1111110 with lo=0000000 -> value=4'b1000.
  - hi=1111110 with lo=1001111 -> value=4'b1111.
  - hi=1111110 with lo=0100000 -> value=4'b1010.
  - Each pattern held 6 cycles; err=0 on all.
- Glitch rejection:
  - Pattern "3" (lo=0000110) held 2 cycles then "5" held 3 cycles -> no emit.
  - Then "5" held 4 cycles -> single emit, value=4'b0101.
- Illegal patterns:
  - hi=1111110 lo=0000001 (-0) -> err=1, value=0.
  - hi=0000000 with any lo -> err=1.
  - Blank/blank held 10 cycles -> no out_valid.
- Backpressure, out_ready=0:
  - Emit "2", then a stable "4" -> out_valid held, value stays 4'b0010, overrun=1.
  - Raise out_ready together with a new emit of "6" -> value=4'b0110 loaded, out_valid stays 1, overrun stays 1 until reset.
